alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle MIPS ALU.
- Executes single-cycle ALU ops (ADD/SUB/AND/OR/NOR/SLT/SLTU/SLL/SRL/SRA) with a valid/ready issue handshake.
- Executes iterative unsigned MULTU/DIVU into HI/LO registers, and MFHI/MFLO to read them.
- Sits in the EX stage; the pipeline stalls on in_ready low while a multi-cycle op runs.

---
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - issue/result bundle between the EX-stage issuer and alu_seq
//
// Purpose: carries one ALU op per handshake from the issuer to the ALU, and
//          returns the registered result plus the HI/LO register contents.
// Signals:
//   in_valid, alu_op, rs, rt, shamt   issuer -> ALU, op presented for issue
//   in_ready                          ALU -> issuer, op accepted this cycle when high with in_valid
//   out_valid                         ALU -> issuer, single-cycle pulse, no backpressure
//   result, zero, overflow            ALU -> issuer, held until the next out_valid
//   hi, lo                            ALU -> issuer, HI/LO register contents
// Modports: master = issuer side, slave = ALU side.

interface alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_op, rs, rt, shamt,
        input  in_ready, out_valid, result, zero, overflow, hi, lo
    );

    modport slave (
        input  in_valid, alu_op, rs, rt, shamt,
        output in_ready, out_valid, result, zero, overflow, hi, lo
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered MIPS-style ALU with iterative MULTU/DIVU and HI/LO
//
// Purpose: executes single-cycle ALU ops with one result per cycle, and
//          WIDTH-cycle shift-add multiply / restoring divide into HI/LO.
// Ports:
//   clock   in   system clock, all state updates on posedge
//   reset   in   synchronous active-high reset
//   bus     slave modport of alu_seq_if (issue handshake, result, hi/lo)

module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic    clock,
    input  logic    reset,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t state, state_nxt;

    logic [SHW-1:0]     cnt;
    // {upper, lower} working register: product/multiplier for MUL,
    // remainder/quotient for DIV. Final layout equals {hi, lo}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   hi_r, lo_r, result_r;
    logic               zero_r, overflow_r, out_valid_r;

    logic accept, is_mul, is_div, last_step;

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.overflow  = overflow_r;
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;

    assign accept    = bus.in_valid && (state == S_IDLE);
    assign is_mul    = (bus.alu_op == OP_MULTU);
    assign is_div    = (bus.alu_op == OP_DIVU);
    assign last_step = (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_nxt = S_MUL;
                end else if (accept && is_div) begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_step) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One multiply step: conditionally add multiplicand to the upper half,
    // then shift the whole register right; the carry lands in the top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // One restoring divide step: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits, shift the outcome into q.
    // With a zero divisor every step "fits", yielding q = all ones and the
    // remainder = dividend without a special case.
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_sh >= {1'b0, opb});
        div_rem  = div_ge ? (div_sh[WIDTH-1:0] - opb) : div_sh[WIDTH-1:0];
        div_next = {div_rem, acc[WIDTH-2:0], div_ge};

        step_next = (state == S_DIV) ? div_next : mul_next;
    end

    logic [WIDTH-1:0] add_r, sub_r, alu_res;
    logic             alu_ovf;

    always_comb begin
        add_r   = bus.rs + bus.rt;
        sub_r   = bus.rs - bus.rt;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                alu_res = add_r;
                alu_ovf = (bus.rs[WIDTH-1] == bus.rt[WIDTH-1]) && (add_r[WIDTH-1] != bus.rs[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_r;
                alu_ovf = (bus.rs[WIDTH-1] != bus.rt[WIDTH-1]) && (sub_r[WIDTH-1] != bus.rs[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.rs & bus.rt;
            OP_OR:   alu_res = bus.rs | bus.rt;
            OP_NOR:  alu_res = ~(bus.rs | bus.rt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.rs) < $signed(bus.rt))};
            OP_SLL:  alu_res = bus.rt << bus.shamt;
            OP_SRL:  alu_res = bus.rt >> bus.shamt;
            OP_SRA:  alu_res = $signed(bus.rt) >>> bus.shamt;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.rs < bus.rt)};
            OP_MFHI: alu_res = hi_r;
            OP_MFLO: alu_res = lo_r;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            acc         <= '0;
            opb         <= '0;
            hi_r        <= '0;
            lo_r        <= '0;
            result_r    <= '0;
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            acc <= {{WIDTH{1'b0}}, bus.rs};
                            opb <= bus.rt;
                            cnt <= '0;
                        end else begin
                            result_r    <= alu_res;
                            zero_r      <= (alu_res == '0);
                            overflow_r  <= alu_ovf;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= step_next;
                    cnt <= cnt + SHW'(1);
                    if (last_step) begin
                        cnt         <= '0;
                        hi_r        <= step_next[2*WIDTH-1:WIDTH];
                        lo_r        <= step_next[WIDTH-1:0];
                        result_r    <= step_next[WIDTH-1:0];
                        zero_r      <= (step_next[WIDTH-1:0] == '0);
                        overflow_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq

module tb_alu_seq;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] m_hi = '0, m_lo = '0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model from the opcode rules, using wide integer arithmetic.
    task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] sh, output logic [W-1:0] r, output logic ovf);
        int    sa, sb;
        longint s;
        logic [63:0] p;
        sa  = a;
        sb  = b;
        r   = '0;
        ovf = 1'b0;
        case (op)
            4'd1: begin s = longint'(sa) + longint'(sb); r = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd2: begin s = longint'(sa) - longint'(sb); r = W'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = ~(a | b);
            4'd6: r = (sa < sb) ? 1 : 0;
            4'd7: r = b << sh;
            4'd8: r = b >> sh;
            4'd9: r = W'(sb >>> sh);
            4'd10: r = (a < b) ? 1 : 0;
            4'd11: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; end
            4'd12: begin
                if (b == 0) begin m_hi = a; m_lo = '1; end
                else begin m_lo = a / b; m_hi = a % b; end
                r = m_lo;
            end
            4'd13: r = m_hi;
            4'd14: r = m_lo;
            default: r = '0;
        endcase
    endtask

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_out(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.in_ready) busy++;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh, output int lat, output int busy);
        int w;
        @(negedge clock);
        bus.alu_op = op; bus.rs = a; bus.rt = b; bus.shamt = sh; bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin @(negedge clock); w++; end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        wait_out(lat, busy);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [4:0]   sh;
        logic [W-1:0] r;
        logic         z, ov;
    } vec_t;

    initial begin
        int lat, busy, cnt;
        logic [W-1:0] r, a, b;
        logic ov;
        logic [3:0] op;
        logic [4:0] sh;
        vec_t b2b[5];

        reset = 1'b1;
        bus.in_valid = 1'b0; bus.alu_op = '0; bus.rs = '0; bus.rt = '0; bus.shamt = '0;
        @(posedge clock); @(posedge clock); #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        @(negedge clock); reset = 1'b0;

        // Back-to-back single-cycle ops
        b2b[0] = '{4'd1, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b1};
        b2b[1] = '{4'd2, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 1'b0};
        b2b[2] = '{4'd9, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0};
        b2b[3] = '{4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0};
        b2b[4] = '{4'd10, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.alu_op = b2b[i].op; bus.rs = b2b[i].a; bus.rt = b2b[i].b;
            bus.shamt = b2b[i].sh; bus.in_valid = 1'b1;
            @(posedge clock); #1;
            chk($sformatf("b2b%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("b2b%0d_result", i), bus.result, b2b[i].r);
            chk($sformatf("b2b%0d_zero", i), bus.zero, b2b[i].z);
            chk($sformatf("b2b%0d_ovf", i), bus.overflow, b2b[i].ov);
            chk($sformatf("b2b%0d_ready", i), bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        @(posedge clock); #1;
        chk("b2b_idle_valid", bus.out_valid, 0);

        // MULTU max*max
        model_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, r, ov);
        run_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, lat, busy);
        chk("mul_lat", lat, 32);
        chk("mul_busy", busy, 32);
        chk("mul_hi", bus.hi, 32'hFFFFFFFE);
        chk("mul_lo", bus.lo, 32'h00000001);
        chk("mul_result", bus.result, 32'h1);
        chk("mul_ready", bus.in_ready, 1);
        @(posedge clock); #1;
        chk("mul_pulse", bus.out_valid, 0);

        // DIVU
        model_op(4'd12, 32'd100, 32'd7, 5'd0, r, ov);
        run_op(4'd12, 32'd100, 32'd7, 5'd0, lat, busy);
        chk("div_lat", lat, 32);
        chk("div_lo", bus.lo, 14);
        chk("div_hi", bus.hi, 2);
        model_op(4'd12, 32'd9, 32'd0, 5'd0, r, ov);
        run_op(4'd12, 32'd9, 32'd0, 5'd0, lat, busy);
        chk("div0_lat", lat, 32);
        chk("div0_lo", bus.lo, 32'hFFFFFFFF);
        chk("div0_hi", bus.hi, 9);
        chk("div0_ovf", bus.overflow, 0);

        // Stall: ADD held during busy DIVU
        model_op(4'd12, 32'd50, 32'd5, 5'd0, r, ov);
        @(negedge clock);
        bus.alu_op = 4'd12; bus.rs = 32'd50; bus.rt = 32'd5; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.alu_op = 4'd1; bus.rs = 32'd3; bus.rt = 32'd4;
        wait_out(lat, busy);
        chk("stall_lat", lat, 32);
        chk("stall_div_result", bus.result, 10);
        chk("stall_ready", bus.in_ready, 1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        chk("stall_add_valid", bus.out_valid, 1);
        chk("stall_add_result", bus.result, 7);
        @(posedge clock); #1;
        chk("stall_after_valid", bus.out_valid, 0);

        // MFLO in the completion cycle of MULTU 3*4, then NOP
        model_op(4'd11, 32'd3, 32'd4, 5'd0, r, ov);
        run_op(4'd11, 32'd3, 32'd4, 5'd0, lat, busy);
        chk("mf_mul_lat", lat, 32);
        bus.alu_op = 4'd14; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        chk("mflo_valid", bus.out_valid, 1);
        chk("mflo_result", bus.result, 12);
        bus.alu_op = 4'd0;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        chk("nop_result", bus.result, 0);
        chk("nop_zero", bus.zero, 1);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            sh = 5'($urandom_range(0, 31));
            model_op(op, a, b, sh, r, ov);
            run_op(op, a, b, sh, lat, busy);
            chk($sformatf("rnd%0d_op%0d_lat", i, op), lat, (op == 4'd11 || op == 4'd12) ? 32 : 0);
            chk($sformatf("rnd%0d_op%0d_result", i, op), bus.result, r);
            chk($sformatf("rnd%0d_op%0d_zero", i, op), bus.zero, (r == 0));
            chk($sformatf("rnd%0d_op%0d_ovf", i, op), bus.overflow, ov);
            chk($sformatf("rnd%0d_op%0d_hi", i, op), bus.hi, m_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, op), bus.lo, m_lo);
        end

        // Reset mid-MULTU
        @(negedge clock);
        bus.alu_op = 4'd11; bus.rs = 32'h12345; bus.rt = 32'h6789; bus.in_valid = 1'b1;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        chk("midrst_busy", bus.in_ready, 0);
        repeat (5) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        chk("midrst_result", bus.result, 0);
        @(negedge clock); reset = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.out_valid) cnt++;
        end
        chk("midrst_no_result", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
